minterm_table_eval: RTL and testbench

//   Programmable N-variable Boolean function unit. The truth table (ON-set

---
 rtl/minterm_table_eval.sv | 159 +++++++++++++++
 tb/tb_minterm_table_eval.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/minterm_table_eval.sv
// Programmable N_VARS-input Boolean function: serially loaded truth table, optional ON-set count (MINTERM_SCAN_EN).
// Latency: evaluation result registered 1 cycle after accept; scan result 2**N_VARS+1 cycles after scan_start.
// Backpressure: in_ready only in READY with no load_start/scan_start; load_ready only while loading.
module minterm_table_eval #(
    parameter int N_VARS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic              load_bit,
    output logic              load_ready,
    output logic              table_valid,
    input  logic              in_valid,
    input  logic [N_VARS-1:0] in_vars,
    output logic              in_ready,
    output logic              out_valid,
    output logic              out,
    input  logic              scan_start,
    output logic              scan_done,
    output logic [N_VARS:0]   minterm_count
);

    localparam int DEPTH = 1 << N_VARS;
    localparam logic [N_VARS-1:0] LAST_ADDR = '1;

`ifdef MINTERM_SCAN_EN
    typedef enum logic [1:0] {IDLE, LOAD, READY, SCAN} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [DEPTH-1:0]  tbl;
    logic [N_VARS-1:0] addr;
    logic              load_wr;
    logic              eval_acc;
    logic              scan_acc;
    logic              scan_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_ready  = 1'b0;
        table_valid = 1'b0;
        in_ready    = 1'b0;
        load_wr     = 1'b0;
        eval_acc    = 1'b0;
        scan_acc    = 1'b0;
        scan_last   = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) state_nxt = LOAD;
            end
            LOAD: begin
                load_ready = 1'b1;
                // A restart discards the bit presented in the same cycle.
                if (!load_start && load_valid) begin
                    load_wr = 1'b1;
                    if (addr == LAST_ADDR) state_nxt = READY;
                end
            end
            READY: begin
                table_valid = 1'b1;
                if (load_start) begin
                    state_nxt = LOAD;
                end
`ifdef MINTERM_SCAN_EN
                else if (scan_start) begin
                    scan_acc  = 1'b1;
                    state_nxt = SCAN;
                end
`endif
                else begin
                    in_ready = 1'b1;
                    eval_acc = in_valid;
                end
            end
`ifdef MINTERM_SCAN_EN
            SCAN: begin
                table_valid = 1'b1;
                if (load_start) begin
                    state_nxt = LOAD;
                end else if (addr == LAST_ADDR) begin
                    scan_last = 1'b1;
                    state_nxt = READY;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl       <= '0;
            addr      <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= eval_acc;
            if (eval_acc) out <= tbl[in_vars];
            // Every load_start lands in LOAD, so rewinding addr here is always correct.
            if (load_start) begin
                addr <= '0;
            end else if (load_wr) begin
                tbl[addr] <= load_bit;
                addr      <= addr + N_VARS'(1);
            end else if (scan_acc) begin
                addr <= '0;
            end else if (state_nxt != IDLE && scan_busy()) begin
                addr <= addr + N_VARS'(1);
            end
        end
    end

`ifdef MINTERM_SCAN_EN
    logic [N_VARS:0] count;

    function automatic logic scan_busy();
        return (state == SCAN);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            count         <= '0;
            scan_done     <= 1'b0;
            minterm_count <= '0;
        end else begin
            scan_done <= scan_last;
            if (scan_acc) begin
                count <= '0;
            end else if (state == SCAN) begin
                count <= count + (N_VARS+1)'(tbl[addr]);
            end
            if (scan_last) minterm_count <= count + (N_VARS+1)'(tbl[addr]);
        end
    end
`else
    logic unused_scan_start;

    function automatic logic scan_busy();
        return 1'b0;
    endfunction

    assign unused_scan_start = scan_start;
    assign scan_done         = 1'b0;
    assign minterm_count     = '0;
`endif

endmodule

// File: tb/tb_minterm_table_eval.sv
// Directed bench for minterm_table_eval: stimulus pushes expected results with their due cycle,
// a negedge monitor pops and compares whenever out_valid or scan_done is presented.
module tb_minterm_table_eval;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_start, load_valid, load_bit;
    logic         load_ready, table_valid;
    logic         in_valid, in_ready;
    logic [N-1:0] in_vars;
    logic         out_valid, out;
    logic         scan_start, scan_done;
    logic [N:0]   minterm_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {int val; int cyc;} exp_t;
    exp_t out_q[$];
    exp_t cnt_q[$];

    minterm_table_eval #(.N_VARS(N)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_valid(load_valid), .load_bit(load_bit),
        .load_ready(load_ready), .table_valid(table_valid),
        .in_valid(in_valid), .in_vars(in_vars), .in_ready(in_ready),
        .out_valid(out_valid), .out(out),
        .scan_start(scan_start), .scan_done(scan_done), .minterm_count(minterm_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0) begin
            if (out_valid) begin
                if (out_q.size() == 0) begin
                    check("unexpected out_valid", 1, 0);
                end else begin
                    e = out_q.pop_front();
                    check("out value", int'(out), e.val);
                    check("out cycle", cyc, e.cyc);
                end
            end
            if (scan_done) begin
                if (cnt_q.size() == 0) begin
                    check("unexpected scan_done", 1, 0);
                end else begin
                    e = cnt_q.pop_front();
                    check("minterm_count", int'(minterm_count), e.val);
                    check("scan_done cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " load_ready"}, int'(load_ready), 0);
        check({tag, " table_valid"}, int'(table_valid), 0);
        check({tag, " in_ready"}, int'(in_ready), 0);
        check({tag, " out_valid"}, int'(out_valid), 0);
        check({tag, " out"}, int'(out), 0);
        check({tag, " scan_done"}, int'(scan_done), 0);
        check({tag, " minterm_count"}, int'(minterm_count), 0);
    endtask

    // load_valid/load_bit are left as the caller set them during the load_start cycle.
    task automatic load_table(input logic [31:0] pat);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            load_valid = 1'b1;
            load_bit   = pat[i];
            if (i == 0)  check("load_ready in LOAD", int'(load_ready), 1);
            if (i == 31) check("table_valid before last bit", int'(table_valid), 0);
            tick();
        end
        load_valid = 1'b0;
        check("table_valid after load", int'(table_valid), 1);
        check("load_ready after load", int'(load_ready), 0);
    endtask

    task automatic eval(input logic [N-1:0] idx, input int expv);
        in_valid = 1'b1;
        in_vars  = idx;
        out_q.push_back('{expv, cyc + 1});
        tick();
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_bit = 1'b0;
        in_valid = 1'b0; in_vars = '0; scan_start = 1'b0;

        // Test 1: reset, IDLE ignores eval/scan, reset mid-load
        tick(); tick();
        rst = 1'b0;
        check_reset_outputs("reset");
        in_valid = 1'b1; scan_start = 1'b1;
        #1 check("in_ready in IDLE", int'(in_ready), 0);
        tick();
        in_valid = 1'b0; scan_start = 1'b0;
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1; load_bit = 1'b1; tick();
        end
        load_valid = 1'b0;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        check_reset_outputs("mid-load reset");

        // Test 2: 22 ones, index 0 = 1, index 28 = 0
        load_table(32'hEFFF_FC01);
        eval(5'd0, 1);
        eval(5'd28, 0);
        in_valid = 1'b0; tick();

        // Test 3: back-to-back accepts
        eval(5'd0, 1);
        eval(5'd28, 0);
        eval(5'd0, 1);
        eval(5'd31, 1);
        eval(5'd5, 0);
        eval(5'd15, 1);
        in_valid = 1'b0; tick(); tick();

`ifdef MINTERM_SCAN_EN
        // Test 4: ON-set counts
        scan_start = 1'b1;
        cnt_q.push_back('{22, cyc + 33});
        tick();
        scan_start = 1'b0;
        in_valid = 1'b1; in_vars = 5'd0;
        #1 check("in_ready during SCAN", int'(in_ready), 0);
        repeat (10) tick();
        in_valid = 1'b0;
        repeat (30) tick();
        load_table(32'hFFFF_FFFF);
        scan_start = 1'b1;
        cnt_q.push_back('{32, cyc + 33});
        tick();
        scan_start = 1'b0;
        repeat (40) tick();

        // Test 5a: abort a scan with load_start
        scan_start = 1'b1; tick(); scan_start = 1'b0;
        repeat (10) tick();
        load_start = 1'b1; tick(); load_start = 1'b0;
        check("load_ready after abort", int'(load_ready), 1);
        check("table_valid after abort", int'(table_valid), 0);
        check("minterm_count kept after abort", int'(minterm_count), 32);
        repeat (40) tick();
        check("minterm_count still kept", int'(minterm_count), 32);
`else
        // Scan disabled: scan_start does not block evaluation
        scan_start = 1'b1;
        #1 check("in_ready with scan_start", int'(in_ready), 1);
        eval(5'd12, 1);
        in_valid = 1'b0;
        repeat (40) tick();
        scan_start = 1'b0;
        check("minterm_count tied", int'(minterm_count), 0);
        load_start = 1'b1; tick(); load_start = 1'b0;
        check("load_ready after load_start", int'(load_ready), 1);
`endif

        // Test 5b: restart after 7 bits; the restart cycle's bit is discarded
        for (int i = 0; i < 7; i++) begin
            load_valid = 1'b1; load_bit = 1'b1; tick();
        end
        load_valid = 1'b1; load_bit = 1'b1;
        load_table(32'h0000_8001);
        eval(5'd0, 1);
        eval(5'd1, 0);
        eval(5'd15, 1);
        eval(5'd31, 0);
        in_valid = 1'b0; tick();

        // Test 6: load_start beats scan_start and in_valid
        load_start = 1'b1; scan_start = 1'b1; in_valid = 1'b1; in_vars = 5'd0;
        #1 check("in_ready with all requests", int'(in_ready), 0);
        tick();
        load_start = 1'b0; scan_start = 1'b0; in_valid = 1'b0;
        check("load_ready after priority", int'(load_ready), 1);
        check("table_valid after priority", int'(table_valid), 0);
        repeat (40) tick();

        check("pending out results", out_q.size(), 0);
        check("pending scan results", cnt_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
